main_mem_ctrl: RTL and testbench
================================

Name: main_mem_ctrl

Overview:
- Backing-store controller on the memory side of the cache.
- Accepts evicted dirty words from the cache into a small write-back FIFO and retires them into a word-addressed backing SRAM.
- Serves block refills by streaming every word of the requested block back to the cache, one word per cycle, as a write-enable/data/address triple.
- Orders write-back against refill so that a refill always returns data that includes every previously accepted eviction.

Parameters:
- ADDRESS_WIDTH, 32: width of the cache word address.
- DATA_WIDTH, 32: width of one word.
- OFFSET_WIDTH, 6: word-offset bits per block; WORDS_PER_BLOCK = 2**OFFSET_WIDTH.
- MEM_ADDR_WIDTH, 12: backing SRAM depth is 2**MEM_ADDR_WIDTH words, indexed by addr[MEM_ADDR_WIDTH-1:0].
- READ_LATENCY, 2: cycles from SRAM read issue to data valid; must be at least 1.
- WB_DEPTH, 4: number of write-back FIFO entries; must be a power of two.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- evict_valid  in  1  eviction word present.
- evict_addr  in  ADDRESS_WIDTH  word address of the eviction.
- evict_data  in  DATA_WIDTH  eviction data.
- evict_ready  out  1  FIFO can accept; a transfer occurs on evict_valid && evict_ready.
- refill_req  in  1  block refill request.
- refill_addr  in  ADDRESS_WIDTH  any address inside the block; offset bits are ignored.
- refill_busy  out  1  refill latched and in progress.
- refill_we  out  1  refill word valid (drives the cache's main-memory write enable).
- refill_data  out  DATA_WIDTH  refill word.
- refill_word_addr  out  ADDRESS_WIDTH  full word address of refill_data.
- refill_done  out  1  one-cycle pulse, coincident with the last refill_we.
- wb_count  out  $clog2(WB_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset asserted (reset=0):
  - State goes to IDLE; the FIFO is emptied.
  - refill_busy, refill_we, refill_done, refill_data, refill_word_addr and wb_count are 0.
  - evict_ready is forced to 0 while reset is asserted.
  - Backing SRAM contents are not cleared.
  - Reset mid-refill or mid-drain aborts the operation immediately; no further refill_we is issued.
- evict_ready = (wb_count < WB_DEPTH) && !(state==DRAIN) && reset.
  - It is combinational.
  - A full FIFO refuses input even when a dequeue occurs in the same cycle.
- Drain:
  - In IDLE and DRAIN, if the FIFO is non-empty, the head entry is written into the SRAM each cycle (one write per cycle).
  - Entries retire in FIFO order, so the later write to the same address wins.
  - Enqueue and dequeue in the same cycle leave wb_count unchanged.
- Refill acceptance:
  - A request is latched on an edge where refill_req=1 and refill_busy=0; the base address is refill_addr with its offset bits cleared.
  - refill_busy goes to 1 on the next cycle.
  - refill_req is ignored while refill_busy=1; the requester holds it until refill_busy is seen high.
  - An eviction enqueued on the acceptance edge is included in the subsequent drain.
- State machine (single-port SRAM: one access per cycle):
  - IDLE: drain when non-empty. On acceptance go to DRAIN if the FIFO is non-empty after that edge's enqueue/dequeue, else go to READ.
  - DRAIN: evict_ready=0; write one entry per cycle. When the FIFO becomes empty, go to READ.
  - READ: issue SRAM reads for offsets 0..WORDS_PER_BLOCK-1, one per cycle, in ascending order. After the last issue go to WAIT. Evictions are accepted but not drained.
  - WAIT: hold until the read pipeline is empty, then go to IDLE.
  - Refill responses are driven on the edge that retires the last pipeline stage.
- Refill timing:
  - A read issued in cycle k produces refill_we=1, refill_data=mem[base+i] and refill_word_addr=base+i in cycle k+READ_LATENCY.
  - refill_we is high for WORDS_PER_BLOCK consecutive cycles.
  - refill_done=1 only alongside word WORDS_PER_BLOCK-1.
  - refill_busy falls the cycle after refill_done.
  - With an empty FIFO: accept at edge T, READ in T+1..T+WORDS_PER_BLOCK, first refill_we at T+1+READ_LATENCY, refill_done at T+WORDS_PER_BLOCK+READ_LATENCY, refill_busy low at T+WORDS_PER_BLOCK+READ_LATENCY+1.
- Address arithmetic:
  - The SRAM index is the low MEM_ADDR_WIDTH bits of the address; higher bits alias.
  - The offset counter wraps only at the end of the block; the base is never incremented.

Test Plan:
- Reset check: hold reset=0 for 3 cycles, then release → refill_busy=0, refill_we=0, wb_count=0; evict_ready=0 during reset and 1 after release.
- Write-back then refill: evict 0x100..0x103 with data 0xA0..0xA3 back-to-back, then refill_req addr 0x100 → refill words 0..3 = 0xA0..0xA3 at refill_word_addr 0x100..0x103.
- Refill timing: empty FIFO, refill_req addr 0x2000 accepted at edge T → refill_busy=1 at T+1; refill_we at T+3..T+66 (64 cycles); refill_done only at T+66; refill_busy=0 at T+67.
- FIFO full: accept refill 0x000, then drive 5 evictions during READ → the first 4 are accepted, wb_count=4, evict_ready=0, the 5th is held. After the refill completes, drain runs 1 per cycle: wb_count 3,2,1,0, and the 5th is accepted once ready returns.
- Read-after-write ordering: on the same edge, evict 0x2005=0xDEAD and refill_req 0x2000 → state passes through DRAIN; refill word 5 = 0xDEAD; evict_ready=0 while in DRAIN.
- Reset mid-refill: assert reset at refill word 10 → refill_we, refill_done and refill_busy drop immediately. A new refill of the same block after release returns the original memory data.

Source files
------------

// File: rtl/main_mem_ctrl.sv
// Backing-store controller: evictions queue in a write-back FIFO and retire into a single-port SRAM; refills stream a whole block.
// Refill words appear READ_LATENCY cycles after issue; evict_ready drops when the FIFO is full, while draining for a refill, or in reset.
module main_mem_ctrl #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int OFFSET_WIDTH   = 6,
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int READ_LATENCY   = 2,
  parameter int WB_DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       evict_valid,
  input  logic [ADDRESS_WIDTH-1:0]   evict_addr,
  input  logic [DATA_WIDTH-1:0]      evict_data,
  output logic                       evict_ready,
  input  logic                       refill_req,
  input  logic [ADDRESS_WIDTH-1:0]   refill_addr,
  output logic                       refill_busy,
  output logic                       refill_we,
  output logic [DATA_WIDTH-1:0]      refill_data,
  output logic [ADDRESS_WIDTH-1:0]   refill_word_addr,
  output logic                       refill_done,
  output logic [$clog2(WB_DEPTH):0]  wb_count
);
  localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CNT_W = $clog2(WB_DEPTH) + 1;
  localparam int RL    = READ_LATENCY;
  localparam int BW    = ADDRESS_WIDTH - OFFSET_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_READ, S_WAIT} state_t;
  state_t r_state, w_state_nxt;

  logic [DATA_WIDTH-1:0]     r_mem [2**MEM_ADDR_WIDTH];

  logic [MEM_ADDR_WIDTH-1:0] r_fifo_addr [WB_DEPTH];
  logic [DATA_WIDTH-1:0]     r_fifo_dat  [WB_DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]          r_count, w_count_nxt;

  logic [BW-1:0]             r_base;
  logic [OFFSET_WIDTH-1:0]   r_off;
  logic                      r_busy;

  logic                      r_pv    [RL];
  logic                      r_plast [RL];
  logic [ADDRESS_WIDTH-1:0]  r_pa    [RL];
  logic [DATA_WIDTH-1:0]     r_pd    [RL];

  logic                      w_enq, w_deq, w_accept, w_issue, w_last_issue;
  logic [ADDRESS_WIDTH-1:0]  w_rd_addr;
  logic                      w_unused_bits;

  assign w_unused_bits = &{1'b0, evict_addr[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH], refill_addr[OFFSET_WIDTH-1:0]};

  assign evict_ready  = (r_count < CNT_W'(WB_DEPTH)) && (r_state != S_DRAIN) && reset;
  assign w_enq        = evict_valid && evict_ready;
  assign w_deq        = ((r_state == S_IDLE) || (r_state == S_DRAIN)) && (r_count != '0);
  assign w_accept     = refill_req && !r_busy && (r_state == S_IDLE);
  assign w_issue      = (r_state == S_READ);
  assign w_last_issue = w_issue && (r_off == '1);
  assign w_rd_addr    = {r_base, r_off};

  always_comb begin
    w_count_nxt = r_count;
    if (w_enq && !w_deq)
      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_enq && w_deq)
      w_count_nxt = r_count - CNT_W'(1);
  end

  // Evictions accepted on the acceptance edge are drained before any block read.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = (w_count_nxt != '0) ? S_DRAIN : S_READ;
      S_DRAIN: if (w_count_nxt == '0) w_state_nxt = S_READ;
      S_READ:  if (w_last_issue) w_state_nxt = S_WAIT;
      S_WAIT:  if (refill_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_base   <= '0;
      r_off    <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_accept) begin
        r_base <= refill_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
        r_off  <= '0;
        r_busy <= 1'b1;
      end else begin
        if (w_issue) r_off <= r_off + OFFSET_WIDTH'(1);
        if ((r_state == S_WAIT) && refill_done) r_busy <= 1'b0;
      end
    end
  end

  // Control side of the read pipeline; the last stage is the refill output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RL; i++) begin
        r_pv[i]    <= 1'b0;
        r_plast[i] <= 1'b0;
        r_pa[i]    <= '0;
      end
    end else begin
      r_pv[0]    <= w_issue;
      r_plast[0] <= w_last_issue;
      r_pa[0]    <= w_rd_addr;
      for (int i = 1; i < RL; i++) begin
        r_pv[i]    <= r_pv[i-1];
        r_plast[i] <= r_plast[i-1];
        r_pa[i]    <= r_pa[i-1];
      end
    end
  end

  // Storage has no reset so SRAM contents survive it; writes and reads never share a cycle.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_fifo_addr[r_wr_ptr] <= evict_addr[MEM_ADDR_WIDTH-1:0];
      r_fifo_dat[r_wr_ptr]  <= evict_data;
    end
    if (w_deq)
      r_mem[r_fifo_addr[r_rd_ptr]] <= r_fifo_dat[r_rd_ptr];
    if (w_issue)
      r_pd[0] <= r_mem[w_rd_addr[MEM_ADDR_WIDTH-1:0]];
    for (int i = 1; i < RL; i++)
      r_pd[i] <= r_pd[i-1];
  end

  assign refill_busy      = r_busy;
  assign refill_we        = r_pv[RL-1];
  assign refill_done      = r_pv[RL-1] && r_plast[RL-1];
  assign refill_word_addr = r_pa[RL-1];
  assign refill_data      = r_pv[RL-1] ? r_pd[RL-1] : '0;
  assign wb_count         = r_count;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Bench for main_mem_ctrl: a memory model and refill scoreboard check every streamed word,
// while directed sequences check reset, timing, FIFO backpressure, ordering and abort.
module tb_main_mem_ctrl;
  localparam int AW = 32, DW = 32, OW = 6, MAW = 12, RL = 2, WBD = 4;
  localparam int WPB = 2**OW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          evict_valid = 1'b0;
  logic [AW-1:0] evict_addr = '0;
  logic [DW-1:0] evict_data = '0;
  logic          evict_ready;
  logic          refill_req = 1'b0;
  logic [AW-1:0] refill_addr = '0;
  logic          refill_busy, refill_we, refill_done;
  logic [DW-1:0] refill_data;
  logic [AW-1:0] refill_word_addr;
  logic [$clog2(WBD):0] wb_count;

  always #5 clk = ~clk;

  main_mem_ctrl #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET_WIDTH(OW),
    .MEM_ADDR_WIDTH(MAW), .READ_LATENCY(RL), .WB_DEPTH(WBD)
  ) u_dut (
    .clk(clk), .reset(reset),
    .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_data(evict_data),
    .evict_ready(evict_ready),
    .refill_req(refill_req), .refill_addr(refill_addr), .refill_busy(refill_busy),
    .refill_we(refill_we), .refill_data(refill_data), .refill_word_addr(refill_word_addr),
    .refill_done(refill_done), .wb_count(wb_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    logic          last;
  } exp_t;

  logic [DW-1:0] model_mem [2**MAW];
  exp_t          sb_q [$];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int   acc_cyc = 0, n_we = 0, n_done = 0;
  int   first_we_k = -1, done_k = -1, busy_hi_k = -1, busy_low_k = -1;
  logic prev_busy = 1'b0;

  // Monitor: inputs are stable between negedge and the next posedge, so transfers are decided here.
  always @(negedge clk) begin
    int   k;
    exp_t e;
    k = cyc - acc_cyc + 1;
    if (refill_we) begin
      if (n_we == 0) first_we_k = k;
      n_we++;
      if (refill_done) begin
        n_done++;
        done_k = k;
      end
      if (sb_q.size() == 0) begin
        check("sb_underflow", refill_we, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("rf_addr", refill_word_addr, e.addr);
        check("rf_data", refill_data, e.dat);
        check("rf_done", refill_done, e.last);
      end
    end else if (refill_done) begin
      check("done_without_we", refill_done, 1'b0);
    end
    if (!prev_busy && refill_busy) busy_hi_k = k;
    if (prev_busy && !refill_busy) busy_low_k = k;
    prev_busy = refill_busy;
    if (evict_valid && evict_ready)
      model_mem[evict_addr[MAW-1:0]] = evict_data;
    if (reset && refill_req && !refill_busy) begin
      acc_cyc = cyc + 1;
      n_we = 0; n_done = 0;
      first_we_k = -1; done_k = -1; busy_hi_k = -1; busy_low_k = -1;
      for (int i = 0; i < WPB; i++) begin
        e.addr = {refill_addr[AW-1:OW], OW'(i)};
        e.dat  = model_mem[e.addr[MAW-1:0]];
        e.last = (i == WPB - 1);
        sb_q.push_back(e);
      end
    end
  end

  // All driving tasks start and end one time unit after a rising edge.
  task automatic evict(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    evict_valid = 1'b1; evict_addr = a; evict_data = d;
    do begin @(negedge clk); n++; end while (!evict_ready && n < 500);
    if (!evict_ready) check("evict_timeout", evict_ready, 1'b1);
    @(posedge clk); #1;
    evict_valid = 1'b0;
  endtask

  task automatic refill(input logic [AW-1:0] a);
    int n;
    n = 0;
    refill_req = 1'b1; refill_addr = a;
    do begin @(negedge clk); n++; end while (!refill_busy && n < 500);
    check("req_ack", refill_busy, 1'b1);
    @(posedge clk); #1;
    refill_req = 1'b0;
  endtask

  task automatic wait_quiet(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while ((refill_busy || wb_count != 0) && n < 1000);
    check({tag, "_quiet"}, {refill_busy, wb_count}, '0);
    check({tag, "_sb_left"}, sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", refill_busy, 1'b0);
    check("rst_we", refill_we, 1'b0);
    check("rst_count", wb_count, 0);
    check("rst_ready", evict_ready, 1'b0);
    check("rst_data", refill_data, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", evict_ready, 1'b1);
    @(posedge clk); #1;

    // Give the two blocks used below known contents
    for (int i = 0; i < WPB; i++) evict(AW'(i), 32'h5A00_0000 + DW'(i));
    for (int i = 0; i < WPB; i++) evict(AW'(32'h100 + i), 32'h3C00_0000 + DW'(i));
    wait_quiet("prefill");

    // Write-back then refill
    for (int i = 0; i < 4; i++) evict(AW'(32'h100 + i), 32'hA0 + DW'(i));
    refill(32'h100);
    wait_quiet("wb_refill");

    // Refill timing from an empty FIFO; 0x2000 aliases SRAM index 0
    refill(32'h2000);
    wait_quiet("timing");
    check("t_busy_hi", busy_hi_k, 1);
    check("t_first_we", first_we_k, 1 + RL);
    check("t_n_we", n_we, WPB);
    check("t_n_done", n_done, 1);
    check("t_done", done_k, WPB + RL);
    check("t_busy_low", busy_low_k, WPB + RL + 1);

    // FIFO full during READ, fifth eviction held until drain frees a slot
    refill(32'h000);
    for (int i = 0; i < 4; i++) evict(AW'(32'h110 + i), 32'hF0 + DW'(i));
    evict_valid = 1'b1; evict_addr = 32'h114; evict_data = 32'hF4;
    @(negedge clk);
    check("full_count", wb_count, 4);
    check("full_ready", evict_ready, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!evict_ready && n < 500);
    check("fifth_ready", evict_ready, 1'b1);
    check("count_at_ready", wb_count, 3);
    @(posedge clk); #1;
    evict_valid = 1'b0;
    for (int j = 3; j >= 0; j--) begin
      @(negedge clk);
      check("drain_count", wb_count, j);
    end
    @(posedge clk); #1;
    wait_quiet("fifo_full");
    refill(32'h100);
    wait_quiet("drained_data");

    // Eviction and refill on the same edge: the refill must see the new word
    evict_valid = 1'b1; evict_addr = 32'h2005; evict_data = 32'hDEAD;
    refill_req = 1'b1; refill_addr = 32'h2000;
    @(negedge clk);
    check("raw_ready_pre", evict_ready, 1'b1);
    check("raw_busy_pre", refill_busy, 1'b0);
    @(posedge clk); #1;
    evict_valid = 1'b0;
    @(negedge clk);
    check("raw_busy", refill_busy, 1'b1);
    check("raw_drain_ready", evict_ready, 1'b0);
    check("raw_drain_count", wb_count, 1);
    @(posedge clk); #1;
    refill_req = 1'b0;
    @(negedge clk);
    check("raw_read_ready", evict_ready, 1'b1);
    @(posedge clk); #1;
    wait_quiet("raw");

    // Reset in the middle of a refill
    refill(32'h000);
    n = 0;
    do begin @(negedge clk); n++; end
      while (!(refill_we && refill_word_addr[OW-1:0] == 6'd10) && n < 500);
    check("abort_word10", refill_word_addr[OW-1:0], 10);
    #2 reset = 1'b0;
    #1;
    check("abort_we", refill_we, 1'b0);
    check("abort_done", refill_done, 1'b0);
    check("abort_busy", refill_busy, 1'b0);
    check("abort_ready", evict_ready, 1'b0);
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    refill(32'h000);
    wait_quiet("after_abort");
    check("after_abort_n_we", n_we, WPB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end

endmodule
